// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack memory port and feeds IF/ID.
// Optional wait-cycle performance counter enabled by defining IFU_PERF_CNT_EN.
module if_fetch_unit #(
    parameter int unsigned       PCSIZE   = 32,
    parameter int unsigned       ISTRSIZE = 32,
    parameter logic [PCSIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                r_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PCSIZE-1:0]   redirect_pc,
    output logic                imem_req_o,
    output logic [PCSIZE-1:0]   imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [ISTRSIZE-1:0] imem_rdata_i,
    output logic [ISTRSIZE-1:0] IF_instr_o,
    output logic [PCSIZE-1:0]   IF_pc_o,
    output logic                IF_valid_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_wait_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [PCSIZE-1:0]   pc_q, pc_d;
    logic [PCSIZE-1:0]   req_addr_q, req_addr_d;
    logic [ISTRSIZE-1:0] o_instr_q, o_instr_d;
    logic [PCSIZE-1:0]   o_pc_q, o_pc_d;
    logic                o_valid_q, o_valid_d;
    logic [ISTRSIZE-1:0] s_instr_q, s_instr_d;
    logic [PCSIZE-1:0]   s_pc_q, s_pc_d;
    logic                s_full_q, s_full_d;
    logic                consume;
    logic                ack_acc;

    assign consume     = !stall;
    // Gated by r_n so the request drops the instant reset asserts.
    assign imem_req_o  = r_n && (state_q != ST_HOLD);
    assign imem_addr_o = req_addr_q;
    assign ack_acc     = imem_req_o && imem_ack_i;

    assign IF_instr_o  = o_instr_q;
    assign IF_pc_o     = o_pc_q;
    assign IF_valid_o  = o_valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        o_instr_d  = o_instr_q;
        o_pc_d     = o_pc_q;
        o_valid_d  = o_valid_q;
        s_instr_d  = s_instr_q;
        s_pc_d     = s_pc_q;
        s_full_d   = s_full_q;

        if (consume) begin
            if (s_full_q) begin
                o_instr_d = s_instr_q;
                o_pc_d    = s_pc_q;
                o_valid_d = 1'b1;
                s_full_d  = 1'b0;
            end else begin
                o_instr_d = '0;
                o_pc_d    = '0;
                o_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_REQ: begin
                if (ack_acc) begin
                    pc_d       = pc_q + PCSIZE'(4);
                    req_addr_d = pc_q + PCSIZE'(4);
                    if (!o_valid_q || consume) begin
                        o_instr_d = imem_rdata_i;
                        o_pc_d    = pc_q;
                        o_valid_d = 1'b1;
                    end else begin
                        s_instr_d = imem_rdata_i;
                        s_pc_d    = pc_q;
                        s_full_d  = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_DRAIN: begin
                // Response to the pre-redirect address: drop it and refetch from pc.
                if (ack_acc) begin
                    req_addr_d = pc_q;
                    state_d    = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (consume) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (redirect) begin
            pc_d      = redirect_pc;
            o_instr_d = '0;
            o_pc_d    = '0;
            o_valid_d = 1'b0;
            s_instr_d = '0;
            s_pc_d    = '0;
            s_full_d  = 1'b0;
            if (state_q == ST_HOLD || ack_acc) begin
                req_addr_d = redirect_pc;
                state_d    = ST_REQ;
            end else begin
                // Outstanding request must complete before the new target is issued.
                req_addr_d = req_addr_q;
                state_d    = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            o_instr_q  <= '0;
            o_pc_q     <= '0;
            o_valid_q  <= 1'b0;
            s_instr_q  <= '0;
            s_pc_q     <= '0;
            s_full_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            o_instr_q  <= o_instr_d;
            o_pc_q     <= o_pc_d;
            o_valid_q  <= o_valid_d;
            s_instr_q  <= s_instr_d;
            s_pc_q     <= s_pc_d;
            s_full_q   <= s_full_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (imem_req_o && !imem_ack_i && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_wait_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: wait-state memory model, delivery scoreboard and directed checks.
module tb_if_fetch_unit;

    localparam logic [31:0] PATTERN = 32'hA5A5_A5A5;

    logic        clk;
    logic        r_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] IF_instr_o;
    logic [31:0] IF_pc_o;
    logic        IF_valid_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_wait_cnt_o;
`endif

    int          checks = 0;
    int          errors = 0;
    int          wait_states = 0;
    logic        mem_hold = 1'b0;
    int          waited;
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc = 32'h0;

    if_fetch_unit #(
        .PCSIZE  (32),
        .ISTRSIZE(32),
        .RESET_PC(32'h0)
    ) dut (
        .clk         (clk),
        .r_n         (r_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_rdata_i(imem_rdata_i),
        .IF_instr_o  (IF_instr_o),
        .IF_pc_o     (IF_pc_o),
        .IF_valid_o  (IF_valid_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_wait_cnt_o(perf_wait_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after wait_states wait cycles, data = addr ^ PATTERN.
    always @(posedge clk or negedge r_n) begin
        if (!r_n) waited <= 0;
        else if (!imem_req_o || imem_ack_i) waited <= 0;
        else waited <= waited + 1;
    end
    assign imem_ack_i   = imem_req_o && !mem_hold && (waited >= wait_states);
    assign imem_rdata_i = imem_ack_i ? (imem_addr_o ^ PATTERN) : 32'h0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        r_n = 1'b0;
        tick();
        tick();
        r_n = 1'b1;
    endtask

    // Scoreboard: an ack on the expected next address is a transaction owed to IF/ID.
    always @(negedge clk) begin
        if (!r_n) begin
            sb_q.delete();
            exp_pc = 32'h0;
        end else begin
            if (IF_valid_o && !stall && !redirect) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_extra", 64'(sb_q.size()), 64'd1);
                end else begin
                    logic [63:0] e;
                    e = sb_q.pop_front();
                    $display("IFID pc=0x%08h instr=0x%08h", IF_pc_o, IF_instr_o);
                    check_val("sb_pc", 64'(IF_pc_o), 64'(e[63:32]));
                    check_val("sb_instr", 64'(IF_instr_o), 64'(e[31:0]));
                end
            end
            if (redirect) begin
                sb_q.delete();
                exp_pc = redirect_pc;
            end else if (imem_req_o && imem_ack_i && imem_addr_o == exp_pc) begin
                sb_q.push_back({exp_pc, exp_pc ^ PATTERN});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    initial begin
        r_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) tick();
        check_val("rst_req", 64'(imem_req_o), 64'd0);
        check_val("rst_valid", 64'(IF_valid_o), 64'd0);
        check_val("rst_instr", 64'(IF_instr_o), 64'd0);
        check_val("rst_pc", 64'(IF_pc_o), 64'd0);
`ifdef IFU_PERF_CNT_EN
        check_val("rst_perf", 64'(perf_wait_cnt_o), 64'd0);
`endif
        r_n = 1'b1;
        #1;
        check_val("rel_req", 64'(imem_req_o), 64'd1);
        check_val("rel_addr", 64'(imem_addr_o), 64'd0);

        // Zero-wait streaming
        tick();
        for (int i = 0; i < 4; i++) begin
            check_val("zw_pc", 64'(IF_pc_o), 64'(4 * i));
            check_val("zw_instr", 64'(IF_instr_o), 64'((32'(4 * i)) ^ PATTERN));
            check_val("zw_valid", 64'(IF_valid_o), 64'd1);
            tick();
        end

        // Asynchronous reset while O holds a valid instruction
        r_n = 1'b0;
        #1;
        check_val("ar_valid", 64'(IF_valid_o), 64'd0);
        check_val("ar_pc", 64'(IF_pc_o), 64'd0);
        check_val("ar_req", 64'(imem_req_o), 64'd0);
        tick();
        tick();
        r_n = 1'b1;

        // Stall for 3 edges at O.pc=8
        repeat (3) tick();
        check_val("st_pc_pre", 64'(IF_pc_o), 64'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("st_pc_hold", 64'(IF_pc_o), 64'h8);
            check_val("st_req_low", 64'(imem_req_o), 64'd0);
        end
        stall = 1'b0;
        tick();
        check_val("st_pc_rel", 64'(IF_pc_o), 64'hC);
        check_val("st_valid_rel", 64'(IF_valid_o), 64'd1);
        check_val("st_req_rel", 64'(imem_req_o), 64'd1);
        check_val("st_addr_rel", 64'(imem_addr_o), 64'h10);
        tick();
        check_val("st_pc_next", 64'(IF_pc_o), 64'h10);

        // Wait states at 0x20 with redirect to 0x100 in the first wait cycle
        for (int i = 0; i < 20 && imem_addr_o != 32'h20; i++) tick();
        check_val("wr_reach", 64'(imem_addr_o), 64'h20);
        mem_hold = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check_val("wr_valid", 64'(IF_valid_o), 64'd0);
        check_val("wr_instr", 64'(IF_instr_o), 64'd0);
        check_val("wr_addr1", 64'(imem_addr_o), 64'h20);
        check_val("wr_req1", 64'(imem_req_o), 64'd1);
        tick();
        check_val("wr_addr2", 64'(imem_addr_o), 64'h20);
        tick();
        check_val("wr_addr3", 64'(imem_addr_o), 64'h20);
        mem_hold = 1'b0;
        tick();
        check_val("wr_addr_new", 64'(imem_addr_o), 64'h100);
        check_val("wr_valid_gap", 64'(IF_valid_o), 64'd0);
        tick();
        check_val("wr_pc", 64'(IF_pc_o), 64'h100);
        check_val("wr_instr_new", 64'(IF_instr_o), 64'(32'h100 ^ PATTERN));

        // Redirect in the same cycle as ack at 0x10
        do_reset();
        for (int i = 0; i < 20 && imem_addr_o != 32'h10; i++) tick();
        check_val("ra_reach", 64'(imem_addr_o), 64'h10);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check_val("ra_addr", 64'(imem_addr_o), 64'h40);
        check_val("ra_valid", 64'(IF_valid_o), 64'd0);
        tick();
        check_val("ra_pc", 64'(IF_pc_o), 64'h40);
        check_val("ra_instr", 64'(IF_instr_o), 64'(32'h40 ^ PATTERN));

        // Reset while draining
        mem_hold = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        tick();
        check_val("rd_req_drain", 64'(imem_req_o), 64'd1);
        r_n = 1'b0;
        #1;
        check_val("rd_req", 64'(imem_req_o), 64'd0);
        check_val("rd_valid", 64'(IF_valid_o), 64'd0);
        check_val("rd_instr", 64'(IF_instr_o), 64'd0);
        mem_hold = 1'b0;
        tick();
        tick();
        r_n = 1'b1;
        #1;
        check_val("rd_rel_req", 64'(imem_req_o), 64'd1);
        check_val("rd_rel_addr", 64'(imem_addr_o), 64'd0);
        tick();
        check_val("rd_pc0", 64'(IF_pc_o), 64'd0);
        check_val("rd_instr0", 64'(IF_instr_o), 64'(32'h0 ^ PATTERN));

`ifdef IFU_PERF_CNT_EN
        // Two wait states per fetch
        r_n = 1'b0;
        wait_states = 2;
        tick();
        tick();
        r_n = 1'b1;
        repeat (3) tick();
        check_val("pf_cnt1", 64'(perf_wait_cnt_o), 64'd2);
        check_val("pf_pc1", 64'(IF_pc_o), 64'd0);
        repeat (3) tick();
        check_val("pf_cnt2", 64'(perf_wait_cnt_o), 64'd4);
        check_val("pf_pc2", 64'(IF_pc_o), 64'd4);
`endif

        mem_hold = 1'b1;
        repeat (4) tick();
        check_val("sb_left", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
